// File: rtl/cpu_controller_if.sv
// Opcode/zero inputs and datapath strobes between the VeriRISC sequencer and its datapath.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       halt;
  logic       inc_pc;
  logic       ld_ac;
  logic       ld_pc;
  logic       wr;
  logic       data_e;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase VeriRISC sequencer: strobes decode combinationally in the same cycle as their phase.
// Free-running, no wait states or backpressure; only rst releases a halt.
module cpu_controller (
  input  logic             clk,
  input  logic             rst,
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e     phase_q, phase_d;
  logic       halted_q, halted_d;
  logic [2:0] phase_inc;
  phase_e     phase_cur;
  logic       halted_cur;
  logic       aluop;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_inc = phase_q + 3'd1;
    phase_d   = phase_e'(phase_inc);
    halted_d  = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if (phase_q == OP_ADDR && bus.opcode == OP_HLT) begin
      halted_d = 1'b1;
      phase_d  = OP_ADDR;
    end
  end

  // rst forces the phase-0 decode combinationally so outputs are clean while it is held.
  always_comb begin
    phase_cur  = rst ? INST_ADDR : phase_q;
    halted_cur = !rst && halted_q;
    aluop      = (bus.opcode >= OP_ADD) && (bus.opcode <= OP_LDA);

    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.halt   = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.phase  = phase_cur;

    if (halted_cur) begin
      bus.halt = 1'b1;
    end else begin
      case (phase_cur)
        INST_ADDR: begin
          bus.sel = 1'b1;
        end
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = (bus.opcode == OP_HLT);
        end
        OP_FETCH: begin
          bus.rd = aluop;
        end
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.data_e = (bus.opcode == OP_STO);
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.wr     = (bus.opcode == OP_STO);
          bus.data_e = (bus.opcode == OP_STO);
        end
        default: begin
          bus.sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed opcode scenarios plus randomized run against a phase-mask model.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_controller_if b();

  cpu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int tests = 0;
  int fails = 0;

  // Model state: which phase we are in and whether HLT has taken effect.
  int m_phase;
  bit m_halted;

  // Expected {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e,phase} from per-opcode phase masks.
  function automatic logic [11:0] exp_out(input logic r, input logic [2:0] op, input logic z);
    logic       alu;
    logic [7:0] sel_m, rd_m, ldir_m, halt_m, inc_m, ldac_m, ldpc_m, wr_m, de_m;
    if (r) return {1'b1, 8'b0, 3'd0};
    if (m_halted) return {3'b000, 1'b1, 5'b0, 3'd4};
    alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    sel_m  = 8'b0000_1111;
    rd_m   = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
    ldir_m = 8'b0000_1100;
    halt_m = (op == 3'd0) ? 8'b0001_0000 : 8'h00;
    inc_m  = 8'b0001_0000 | ((op == 3'd1 && z) ? 8'b0100_0000 : 8'h00);
    ldac_m = alu ? 8'b1000_0000 : 8'h00;
    ldpc_m = (op == 3'd7) ? 8'b1100_0000 : 8'h00;
    wr_m   = (op == 3'd6) ? 8'b1000_0000 : 8'h00;
    de_m   = (op == 3'd6) ? 8'b1100_0000 : 8'h00;
    return {sel_m[m_phase], rd_m[m_phase], ldir_m[m_phase], halt_m[m_phase], inc_m[m_phase],
            ldac_m[m_phase], ldpc_m[m_phase], wr_m[m_phase], de_m[m_phase], 3'(m_phase)};
  endfunction

  function automatic logic [11:0] got();
    return {b.sel, b.rd, b.ld_ir, b.halt, b.inc_pc, b.ld_ac, b.ld_pc, b.wr, b.data_e, b.phase};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, far from the rising edge.
  task automatic drive(input logic r, input logic [2:0] op, input logic z);
    @(negedge clk);
    rst      = r;
    b.opcode = op;
    b.zero   = z;
    #1;
  endtask

  // Model update for the rising edge that follows the current sample.
  task automatic advance();
    if (rst) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 4 && b.opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
  endtask

  // Reset then one instruction; records each strobe per cycle (cycle index == phase after reset).
  task automatic run_instr(input logic [2:0] op, input logic z, output logic [23:0] trace,
                           output logic [7:0] rd_m, output logic [7:0] inc_m, output logic [7:0] ldac_m,
                           output logic [7:0] ldpc_m, output logic [7:0] wr_m, output logic [7:0] de_m,
                           output logic [7:0] ldir_m);
    drive(1'b1, op, z);
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, op, z);
      trace[3*i +: 3] = b.phase;
      rd_m[i]   = b.rd;
      inc_m[i]  = b.inc_pc;
      ldac_m[i] = b.ld_ac;
      ldpc_m[i] = b.ld_pc;
      wr_m[i]   = b.wr;
      de_m[i]   = b.data_e;
      ldir_m[i] = b.ld_ir;
      advance();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tests++;
      if (got() !== 12'b1_00000000_000) begin
        fails++;
        $display("FAIL reset c%0d got=%b exp=%b", i, got(), 12'b1_00000000_000);
      end
      advance();
    end
  endtask

  task automatic test_add();
    drive(1'b1, 3'd2, 1'b0);
    advance();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 3'd2, 1'($urandom_range(0, 1)));
      tests++;
      if (got() !== exp_out(rst, b.opcode, b.zero)) begin
        fails++;
        $display("FAIL add_vec c%0d got=%b exp=%b", c, got(), exp_out(rst, b.opcode, b.zero));
      end
      tests++;
      if (b.phase !== 3'(c % 8) || b.ld_ac !== (c == 7)) begin
        fails++;
        $display("FAIL add_phase c%0d phase=%0d ld_ac=%b exp_phase=%0d", c, b.phase, b.ld_ac, c % 8);
      end
      advance();
    end
  endtask

  task automatic test_skz();
    logic [23:0] tr;
    logic [7:0]  rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m;
    for (int zv = 1; zv >= 0; zv--) begin
      run_instr(3'd1, 1'(zv), tr, rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m);
      tests++;
      if (inc_m !== (zv ? 8'b0101_0000 : 8'b0001_0000)) begin
        fails++;
        $display("FAIL skz_inc zero=%0d got=%b", zv, inc_m);
      end
      tests++;
      if (rd_m !== 8'b0000_1110 || ldac_m !== 8'h00 || tr !== 24'o76543210) begin
        fails++;
        $display("FAIL skz_rd zero=%0d rd=%b ld_ac=%b trace=%o", zv, rd_m, ldac_m, tr);
      end
    end
  endtask

  task automatic test_sto();
    logic [23:0] tr;
    logic [7:0]  rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m;
    run_instr(3'd6, 1'b1, tr, rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m);
    tests++;
    if (de_m !== 8'b1100_0000 || wr_m !== 8'b1000_0000) begin
      fails++;
      $display("FAIL sto_wr data_e=%b wr=%b", de_m, wr_m);
    end
    tests++;
    if (rd_m !== 8'b0000_1110 || ldac_m !== 8'h00 || ldir_m !== 8'b0000_1100) begin
      fails++;
      $display("FAIL sto_rd rd=%b ld_ac=%b ld_ir=%b", rd_m, ldac_m, ldir_m);
    end
  endtask

  task automatic test_jmp();
    logic [23:0] tr;
    logic [7:0]  rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m;
    run_instr(3'd7, 1'b1, tr, rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m);
    tests++;
    if (ldpc_m !== 8'b1100_0000 || inc_m !== 8'b0001_0000 || wr_m !== 8'h00) begin
      fails++;
      $display("FAIL jmp ld_pc=%b inc_pc=%b wr=%b", ldpc_m, inc_m, wr_m);
    end
  endtask

  task automatic test_hlt();
    drive(1'b1, 3'd0, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 1'b0);
      advance();
    end
    drive(1'b0, 3'd0, 1'b0);
    tests++;
    if (b.phase !== 3'd4 || b.halt !== 1'b1 || b.inc_pc !== 1'b1) begin
      fails++;
      $display("FAIL hlt_enter phase=%0d halt=%b inc_pc=%b", b.phase, b.halt, b.inc_pc);
    end
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tests++;
      if (got() !== 12'b000_1_00000_100) begin
        fails++;
        $display("FAIL hlt_hold c%0d got=%b exp=%b", i, got(), 12'b000_1_00000_100);
      end
      advance();
    end
    drive(1'b1, 3'd0, 1'b0);
    advance();
    drive(1'b0, 3'd2, 1'b0);
    tests++;
    if (b.phase !== 3'd0 || b.halt !== 1'b0 || b.sel !== 1'b1) begin
      fails++;
      $display("FAIL hlt_release phase=%0d halt=%b sel=%b", b.phase, b.halt, b.sel);
    end
    advance();
  endtask

  task automatic test_rst_mid();
    logic        ac_seen;
    logic [23:0] tr;
    logic [7:0]  rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m;
    ac_seen = 1'b0;
    drive(1'b1, 3'd5, 1'b0);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd5, 1'b0);
      ac_seen |= b.ld_ac;
      advance();
    end
    drive(1'b1, 3'd5, 1'b0);
    ac_seen |= b.ld_ac;
    tests++;
    if (got() !== 12'b1_00000000_000) begin
      fails++;
      $display("FAIL rst_mid_hold got=%b exp=%b", got(), 12'b1_00000000_000);
    end
    advance();
    drive(1'b0, 3'd5, 1'b0);
    ac_seen |= b.ld_ac;
    tests++;
    if (b.phase !== 3'd0 || ac_seen !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_abort phase=%0d ld_ac_seen=%b", b.phase, ac_seen);
    end
    advance();
    run_instr(3'd5, 1'b0, tr, rd_m, inc_m, ldac_m, ldpc_m, wr_m, de_m, ldir_m);
    tests++;
    if (ldac_m !== 8'b1000_0000 || rd_m !== 8'b1110_1110 || tr !== 24'o76543210) begin
      fails++;
      $display("FAIL rst_mid_resume ld_ac=%b rd=%b trace=%o", ldac_m, rd_m, tr);
    end
    // Reset landing on the phase-4 HLT edge must win over the halt transition.
    drive(1'b1, 3'd0, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd0, 1'b0);
      advance();
    end
    drive(1'b1, 3'd0, 1'b0);
    advance();
    drive(1'b0, 3'd0, 1'b0);
    advance();
    drive(1'b0, 3'd0, 1'b0);
    tests++;
    if (b.phase !== 3'd1 || b.halt !== 1'b0 || b.rd !== 1'b1) begin
      fails++;
      $display("FAIL rst_hlt phase=%0d halt=%b rd=%b exp phase=1 halt=0 rd=1", b.phase, b.halt, b.rd);
    end
    advance();
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic       r;
    op = 3'd2;
    drive(1'b1, op, 1'b0);
    advance();
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 59) == 0);
      if (m_phase == 0 || $urandom_range(0, 15) == 0) begin
        op = 3'($urandom_range(0, 7));
        if (op == 3'd0 && $urandom_range(0, 2) != 0) op = 3'd3;
      end
      drive(r, op, 1'($urandom_range(0, 1)));
      tests++;
      if (got() !== exp_out(rst, b.opcode, b.zero)) begin
        fails++;
        $display("FAIL random c%0d op=%0d rst=%b zero=%b got=%b exp=%b", c, b.opcode, rst, b.zero,
                 got(), exp_out(rst, b.opcode, b.zero));
      end
      tests++;
      if (b.rd === 1'b1 && b.wr === 1'b1) begin
        fails++;
        $display("FAIL rd_wr_overlap c%0d rd=%b wr=%b", c, b.rd, b.wr);
      end
      if (m_halted && $urandom_range(0, 7) == 0) begin
        drive(1'b1, op, 1'b0);
        advance();
      end else begin
        advance();
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    b.opcode = 3'd0;
    b.zero   = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;
    test_reset();
    test_add();
    test_skz();
    test_sto();
    test_jmp();
    test_hlt();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction sequencer for the VeriRISC CPU. Steps a 3-bit phase counter through fetch, decode and execute, and decodes the current 3-bit opcode plus the ALU accumulator-zero flag into the datapath strobes: memory read/write, IR load, PC increment/load, accumulator load, bus drive and address-mux select. It sits beside the ALU. It consumes the same opcode the ALU receives and the ALU's zero flag, and it produces the `ld_ac` strobe that captures the ALU result.

## Interface
- No parameters (opcode width fixed at 3, phase width fixed at 3).
- `clk` input 1 — single system clock, rising-edge.
- `rst` input 1 — synchronous, active-high reset.
- `opcode` input 3 — instruction opcode from the IR: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero` input 1 — accumulator-is-zero flag from the ALU.
- `sel` output 1 — address mux select: 1=PC, 0=IR operand address.
- `rd` output 1 — memory read enable.
- `ld_ir` output 1 — instruction register load.
- `halt` output 1 — CPU halted/halting indicator.
- `inc_pc` output 1 — program counter increment.
- `ld_ac` output 1 — accumulator load from ALU output.
- `ld_pc` output 1 — program counter load (jump).
- `wr` output 1 — memory write enable.
- `data_e` output 1 — drive accumulator onto data bus.
- `phase` output 3 — current phase, for debug/verification.

## Operation
- State is the 3-bit `phase` register plus a 1-bit `halted` flag. All outputs are combinational decodes of `phase`, `halted`, `opcode` and `zero`.
- ALUOP = opcode in {ADD, AND, XOR, LDA}. Strobes not listed in a phase are 0.
- Phase 0, INST_ADDR: `sel`=1.
- Phase 1, INST_FETCH: `sel`=1, `rd`=1.
- Phase 2, INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
- Phase 3, IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
- Phase 4, OP_ADDR: `inc_pc`=1, `halt`=(opcode==HLT).
- Phase 5, OP_FETCH: `rd`=ALUOP.
- Phase 6, ALU_OP: `rd`=ALUOP, `inc_pc`=(opcode==SKZ && zero), `ld_pc`=(opcode==JMP), `data_e`=(opcode==STO).
- Phase 7, STORE: `rd`=ALUOP, `ld_ac`=ALUOP, `ld_pc`=(opcode==JMP), `wr`=(opcode==STO), `data_e`=(opcode==STO).
- Phase advances by 1 every cycle and wraps 7 -> 0 (modulo 8). There are no wait states.
- Halt: at the clock edge ending phase 4 with opcode==HLT, set `halted`=1 and hold `phase` at 4.
- While `halted`=1: `halt`=1, every other strobe is 0 (including `inc_pc`), and `phase` stays 4. Only `rst` clears it.
- `opcode` is ignored in phases 0–3. It is valid from phase 3 onward after the IR load.
- `zero` is sampled only in phase 6.

## Timing
- Reset: on a rising edge with `rst`=1, `phase`←0 and `halted`←0. This holds whatever phase or halt state is current (reset mid-instruction aborts it).
- Outputs while `rst` is high, or in the cycle after reset: `sel`=1, `phase`=0, all other outputs 0.
- `rst` has priority over the halt transition and phase increment in the same cycle.
- One instruction = 8 cycles.
- Output latency: strobes are valid in the same cycle as their phase, combinationally from inputs. The downstream registers capture on the edge ending that phase.
- SKZ: `inc_pc` is asserted once in phase 4 and again in phase 6 when `zero`=1, giving a net PC+2.
- JMP: `ld_pc` is asserted in both phases 6 and 7.
- STO: `data_e` is asserted in phases 6–7; `wr` only in phase 7.
- No simultaneous read and write: `rd` and `wr` are never both 1.

## Test plan
- Reset, then opcode=ADD for 8 cycles -> `phase` runs 0..7 then 0. `ld_ir` is 1 in phases 2–3 only, `inc_pc` in phase 4 only, `rd` in phases 1,2,3,5,6,7, `ld_ac` in phase 7 only.
- opcode=SKZ with `zero`=1 -> `inc_pc` is 1 in phases 4 and 6. Repeat with `zero`=0 -> `inc_pc` is 1 in phase 4 only; `rd`/`ld_ac` stay 0 in phases 5–7.
- opcode=STO -> `data_e`=1 in phases 6–7, `wr`=1 in phase 7 only, `rd`=0 in phases 5–7, `ld_ac`=0.
- opcode=JMP -> `ld_pc`=1 in phases 6–7, `inc_pc`=1 in phase 4 only, `wr`=0 throughout.
- opcode=HLT -> `halt`=1 and `inc_pc`=1 in phase 4. For the next 20 cycles `phase`=4, `halt`=1, all other strobes 0. Assert `rst` for one cycle -> `phase`=0, `halt`=0, `sel`=1.
- opcode=LDA, assert `rst` during phase 5 -> next cycle `phase`=0 and `ld_ac` never pulses. A full instruction then resumes normally. Also check that `rst` asserted in phase 4 with HLT leaves `halted`=0.
